// File: rtl/ahblite_slave_mux.sv
// ---------------------------------------------------------------------------
// ahblite_slave_mux
// Data-phase response multiplexer for the AHB-Lite fabric. It latches which
// slave owns the current data phase from the decoder selects, then routes that
// slave's HRDATA/HREADYOUT/HRESP back to the master. Unmapped addresses, and
// selects to ports that are not present, are claimed by an integrated default
// slave that answers active transfers with the two-cycle ERROR response.
//
// Ports:
//   HCLK, HRESET            bus clock, synchronous active-high reset
//   HTRANS[1:0]             master transfer type (bit 1 set = NONSEQ/SEQ)
//   Pn_HSEL                 address-phase select from the decoder, n = 0..6
//   Pn_HRDATA[31:0]         read data of slave n
//   Pn_HREADYOUT, Pn_HRESP  ready / error response of slave n
//   HREADY                  bus ready back to master and all slaves
//   HRDATA[31:0], HRESP     muxed read data and response
// ---------------------------------------------------------------------------
module ahblite_slave_mux #(
  parameter bit          PORT0_EN      = 1'b1,
  parameter bit          PORT1_EN      = 1'b1,
  parameter bit          PORT2_EN      = 1'b1,
  parameter bit          PORT3_EN      = 1'b1,
  parameter bit          PORT4_EN      = 1'b1,
  parameter bit          PORT5_EN      = 1'b1,
  parameter bit          PORT6_EN      = 1'b1,
  parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P4_HSEL,
  input  logic        P5_HSEL,
  input  logic        P6_HSEL,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P4_HRDATA,
  input  logic [31:0] P5_HRDATA,
  input  logic [31:0] P6_HRDATA,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P4_HREADYOUT,
  input  logic        P5_HREADYOUT,
  input  logic        P6_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P4_HRESP,
  input  logic        P5_HRESP,
  input  logic        P6_HRESP,
  output logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  // Default-slave FSM encoding
  localparam logic [1:0] ST_OKAY = 2'b00;
  localparam logic [1:0] ST_ERR1 = 2'b01;
  localparam logic [1:0] ST_ERR2 = 2'b10;

  // One-hot owner codes; bit 7 is the default slave
  localparam logic [7:0] OWN_P0  = 8'b0000_0001;
  localparam logic [7:0] OWN_P1  = 8'b0000_0010;
  localparam logic [7:0] OWN_P2  = 8'b0000_0100;
  localparam logic [7:0] OWN_P3  = 8'b0000_1000;
  localparam logic [7:0] OWN_P4  = 8'b0001_0000;
  localparam logic [7:0] OWN_P5  = 8'b0010_0000;
  localparam logic [7:0] OWN_P6  = 8'b0100_0000;
  localparam logic [7:0] OWN_DEF = 8'b1000_0000;

  logic [6:0] hsel_en_s;
  logic [7:0] sel_n_s;
  logic [7:0] sel_q_r;
  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       dflt_ready_s;
  logic       dflt_resp_s;
  logic       err_start_s;

  // Absent ports never raise a select, so their addresses fall to the default slave
  assign hsel_en_s = {P6_HSEL & PORT6_EN, P5_HSEL & PORT5_EN, P4_HSEL & PORT4_EN,
                      P3_HSEL & PORT3_EN, P2_HSEL & PORT2_EN, P1_HSEL & PORT1_EN,
                      P0_HSEL & PORT0_EN};

  // Priority encoder: lowest active select wins, keeping the owner one-hot
  always_comb begin
    sel_n_s = OWN_DEF;
    if      (hsel_en_s[0]) sel_n_s = OWN_P0;
    else if (hsel_en_s[1]) sel_n_s = OWN_P1;
    else if (hsel_en_s[2]) sel_n_s = OWN_P2;
    else if (hsel_en_s[3]) sel_n_s = OWN_P3;
    else if (hsel_en_s[4]) sel_n_s = OWN_P4;
    else if (hsel_en_s[5]) sel_n_s = OWN_P5;
    else if (hsel_en_s[6]) sel_n_s = OWN_P6;
    else                   sel_n_s = OWN_DEF;
  end

  // Data-phase owner register; only advances when the bus completes a beat
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q_r <= OWN_DEF;
    end else if (HREADY) begin
      sel_q_r <= sel_n_s;
    end else begin
      sel_q_r <= sel_q_r;
    end
  end

  // An active transfer to unmapped space accepted on this edge
  assign err_start_s = HREADY & sel_n_s[7] & HTRANS[1];

  // Default-slave next state and its ready/response, which depend on state only
  // so that the bus HREADY cannot loop back through the FSM combinationally
  always_comb begin
    state_nxt_s  = ST_OKAY;
    dflt_ready_s = 1'b1;
    dflt_resp_s  = 1'b0;
    case (state_r)
      ST_OKAY: begin
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b0;
        state_nxt_s  = err_start_s ? ST_ERR1 : ST_OKAY;
      end
      ST_ERR1: begin
        dflt_ready_s = 1'b0;
        dflt_resp_s  = 1'b1;
        state_nxt_s  = ST_ERR2;
      end
      ST_ERR2: begin
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b1;
        state_nxt_s  = err_start_s ? ST_ERR1 : ST_OKAY;
      end
      default: begin
        dflt_ready_s = 1'b1;
        dflt_resp_s  = 1'b0;
        state_nxt_s  = ST_OKAY;
      end
    endcase
  end

  // Default-slave state register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r <= ST_OKAY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Response mux driven purely by the registered owner (no added latency)
  always_comb begin
    HRDATA = DEFAULT_RDATA;
    HREADY = dflt_ready_s;
    HRESP  = dflt_resp_s;
    case (sel_q_r)
      OWN_P0: begin HRDATA = P0_HRDATA; HREADY = P0_HREADYOUT; HRESP = P0_HRESP; end
      OWN_P1: begin HRDATA = P1_HRDATA; HREADY = P1_HREADYOUT; HRESP = P1_HRESP; end
      OWN_P2: begin HRDATA = P2_HRDATA; HREADY = P2_HREADYOUT; HRESP = P2_HRESP; end
      OWN_P3: begin HRDATA = P3_HRDATA; HREADY = P3_HREADYOUT; HRESP = P3_HRESP; end
      OWN_P4: begin HRDATA = P4_HRDATA; HREADY = P4_HREADYOUT; HRESP = P4_HRESP; end
      OWN_P5: begin HRDATA = P5_HRDATA; HREADY = P5_HREADYOUT; HRESP = P5_HRESP; end
      OWN_P6: begin HRDATA = P6_HRDATA; HREADY = P6_HREADYOUT; HRESP = P6_HRESP; end
      default: begin
        HRDATA = DEFAULT_RDATA;
        HREADY = dflt_ready_s;
        HRESP  = dflt_resp_s;
      end
    endcase
  end

endmodule
